// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and limits for the truth-table sweeper.
//   sweep_state_e : sweeper FSM states (IDLE, RUN, DONE)
//   N_IN_MAX      : largest supported number of function inputs
//   SETTLE_MAX    : largest supported settle window (cycles)
//   tt_width(n)   : truth-table width for an n-input function (2^n)
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    localparam int N_IN_MAX   = 8;
    localparam int SETTLE_MAX = 15;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/status bundle between a host and the truth-table sweeper.
//   start, abort, tt_expected : host -> sweeper
//   busy, done, pass          : sweep status
//   err_count, err_valid,
//   first_err_vec             : mismatch summary of the current/last sweep
//   obs_map                   : observed truth table, only when
//                               TT_SWEEP_OBSMAP_EN is defined
// Modports: master (host side), slave (sweeper side).
interface tt_sweep_if
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 4
);
    logic                      start;
    logic                      abort;
    logic [tt_width(N_IN)-1:0] tt_expected;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [N_IN:0]             err_count;
    logic                      err_valid;
    logic [N_IN-1:0]           first_err_vec;
`ifdef TT_SWEEP_OBSMAP_EN
    logic [tt_width(N_IN)-1:0] obs_map;

    modport master (
        output start, abort, tt_expected,
        input  busy, done, pass, err_count, err_valid, first_err_vec, obs_map
    );
    modport slave (
        input  start, abort, tt_expected,
        output busy, done, pass, err_count, err_valid, first_err_vec, obs_map
    );
`else
    modport master (
        output start, abort, tt_expected,
        input  busy, done, pass, err_count, err_valid, first_err_vec
    );
    modport slave (
        input  start, abort, tt_expected,
        output busy, done, pass, err_count, err_valid, first_err_vec
    );
`endif
endinterface

// File: rtl/truth_table_sweeper_err_tracker.sv
// Mismatch bookkeeping for one sweep.
//   clk, rst_n     : clock, async active-low reset
//   clear          : start of a new sweep, zeroes all fields
//   sample         : one strobe per evaluated vector
//   mismatch       : sampled output disagreed with the golden bit
//   vec            : vector being sampled
//   err_count      : mismatches so far (N_IN+1 bits, cannot overflow)
//   err_valid      : at least one mismatch seen
//   first_err_vec  : vector of the first mismatch
module tt_err_tracker #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            sample,
    input  logic            mismatch,
    input  logic [N_IN-1:0] vec,
    output logic [N_IN:0]   err_count,
    output logic            err_valid,
    output logic [N_IN-1:0] first_err_vec
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count     <= '0;
            err_valid     <= 1'b0;
            first_err_vec <= '0;
        end else if (clear) begin
            err_count     <= '0;
            err_valid     <= 1'b0;
            first_err_vec <= '0;
        end else if (sample && mismatch) begin
            err_count <= err_count + 1'b1;
            if (!err_valid) begin
                err_valid     <= 1'b1;
                first_err_vec <= vec;
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sequential self-checker for an N_IN-input, single-output combinational
// function. Drives every vector 0..2^N_IN-1, holds each for SETTLE+1 cycles,
// samples y_i on the last of them and compares against the latched golden
// table.
//   clk, rst_n : clock, async active-low reset
//   sw         : tt_sweep_if slave (start/abort/golden in, status out)
//   vec_o      : vector driven to the function under test
//   y_i        : function output
// Optional: TT_SWEEP_OBSMAP_EN adds sw.obs_map, the observed truth table.
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep held
// RUN   | stepping vectors, sampling after each settle window
// DONE  | one-cycle completion pulse, then back to IDLE
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    tt_sweep_if.slave       sw,
    output logic [N_IN-1:0] vec_o,
    input  logic            y_i
);

    localparam int         TT_W     = tt_width(N_IN);
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    sweep_state_e    state, state_n;
    logic [TT_W-1:0] tt_q;
    logic [3:0]      cnt;
    logic            load, sample, finish, quit;
    logic            last_vec, mismatch;
    logic [N_IN:0]   err_count;

    assign last_vec = &vec_o;
    assign mismatch = (y_i != tt_q[vec_o]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Abort outranks a coinciding sample edge: the partial vector is dropped.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        sample  = 1'b0;
        finish  = 1'b0;
        quit    = 1'b0;
        sw.busy = 1'b0;
        sw.done = 1'b0;
        case (state)
            IDLE: begin
                if (sw.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                sw.busy = 1'b1;
                if (sw.abort) begin
                    quit    = 1'b1;
                    state_n = IDLE;
                end else if (cnt == SETTLE_L) begin
                    sample = 1'b1;
                    if (last_vec) begin
                        finish  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                sw.done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // pass is registered on the final sample edge so it is already valid
    // while done is high; it folds in a mismatch on that last vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_o   <= '0;
            cnt     <= '0;
            tt_q    <= '0;
            sw.pass <= 1'b0;
        end else if (load) begin
            vec_o   <= '0;
            cnt     <= '0;
            tt_q    <= sw.tt_expected;
            sw.pass <= 1'b0;
        end else if (quit) begin
            sw.pass <= 1'b0;
        end else if (sample) begin
            cnt <= '0;
            if (!last_vec) vec_o <= vec_o + 1'b1;
            if (finish)    sw.pass <= (err_count == '0) && !mismatch;
        end else if (state == RUN) begin
            cnt <= cnt + 4'd1;
        end
    end

    tt_err_tracker #(.N_IN(N_IN)) u_err (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (load),
        .sample        (sample),
        .mismatch      (mismatch),
        .vec           (vec_o),
        .err_count     (err_count),
        .err_valid     (sw.err_valid),
        .first_err_vec (sw.first_err_vec)
    );

    assign sw.err_count = err_count;

`ifdef TT_SWEEP_OBSMAP_EN
    logic [TT_W-1:0] obs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      obs_q <= '0;
        else if (load)   obs_q <= '0;
        else if (sample) obs_q[vec_o] <= y_i;
    end

    assign sw.obs_map = obs_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // A: N_IN=3 SETTLE=1, y = ~A~B~C | A~BC
    // B: N_IN=4 SETTLE=0, y tied 0
    // C: N_IN=3 SETTLE=2, y = A^B^C
    tt_sweep_if #(.N_IN(3)) ifa ();
    tt_sweep_if #(.N_IN(4)) ifb ();
    tt_sweep_if #(.N_IN(3)) ifc ();

    logic [2:0] vec_a;
    logic [3:0] vec_b;
    logic [2:0] vec_c;
    logic       ya, yb, yc;

    assign ya = (~vec_a[2] & ~vec_a[1] & ~vec_a[0]) | (vec_a[2] & ~vec_a[1] & vec_a[0]);
    assign yb = 1'b0;
    assign yc = ^vec_c;

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .sw(ifa), .vec_o(vec_a), .y_i(ya));
    truth_table_sweeper #(.N_IN(4), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .sw(ifb), .vec_o(vec_b), .y_i(yb));
    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .sw(ifc), .vec_o(vec_c), .y_i(yc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.tt_expected = '0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.tt_expected = '0;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.tt_expected = '0;

        // reset state
        tick(2);
        check("rst_vec_a",  32'(vec_a), 32'd0);
        check("rst_busy_a", 32'(ifa.busy), 32'd0);
        check("rst_done_a", 32'(ifa.done), 32'd0);
        check("rst_pass_a", 32'(ifa.pass), 32'd0);
        check("rst_err_b",  32'(ifb.err_count), 32'd0);
        check("rst_vld_c",  32'(ifc.err_valid), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // sweep 1: correct golden table, A
        ifa.tt_expected = 8'b0010_0001;
        ifa.start = 1'b1;
        tick(1);                                   // after E0
        ifa.start = 1'b0;
        ifa.tt_expected = 8'b1111_1111;            // must already be latched
        check("s1_busy_e0", 32'(ifa.busy), 32'd1);
        check("s1_vec_e0",  32'(vec_a), 32'd0);
        tick(1);
        check("s1_vec_e1",  32'(vec_a), 32'd0);
        tick(1);
        check("s1_vec_e2",  32'(vec_a), 32'd1);
        tick(13);                                  // after E15
        check("s1_done_e15", 32'(ifa.done), 32'd0);
        check("s1_busy_e15", 32'(ifa.busy), 32'd1);
        check("s1_vec_e15",  32'(vec_a), 32'd7);
        tick(1);                                   // after E16
        check("s1_done_e16", 32'(ifa.done), 32'd1);
        check("s1_busy_e16", 32'(ifa.busy), 32'd0);
        check("s1_pass",     32'(ifa.pass), 32'd1);
        check("s1_errcnt",   32'(ifa.err_count), 32'd0);
        check("s1_errvld",   32'(ifa.err_valid), 32'd0);
        check("s1_vec_hold", 32'(vec_a), 32'd7);
        tick(1);                                   // after E17
        check("s1_done_e17", 32'(ifa.done), 32'd0);
        check("s1_pass_hold", 32'(ifa.pass), 32'd1);

        // sweep 2: one wrong golden bit, start pulse during RUN ignored
        ifa.tt_expected = 8'b0010_0011;
        ifa.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
        check("s2_pass_clr", 32'(ifa.pass), 32'd0);
        tick(5);                                   // after E5
        ifa.start = 1'b1;
        tick(1);                                   // after E6
        ifa.start = 1'b0;
        tick(9);                                   // after E15
        check("s2_done_e15", 32'(ifa.done), 32'd0);
        check("s2_busy_e15", 32'(ifa.busy), 32'd1);
        tick(1);                                   // after E16
        check("s2_done_e16", 32'(ifa.done), 32'd1);
        check("s2_pass",     32'(ifa.pass), 32'd0);
        check("s2_errcnt",   32'(ifa.err_count), 32'd1);
        check("s2_errvld",   32'(ifa.err_valid), 32'd1);
        check("s2_first",    32'(ifa.first_err_vec), 32'd1);
        tick(1);
        check("s2_done_e17",   32'(ifa.done), 32'd0);
        check("s2_errcnt_hold", 32'(ifa.err_count), 32'd1);

        // sweep 3: B, every vector mismatches, err_count reaches 2^N_IN
        ifb.tt_expected = 16'hFFFF;
        ifb.start = 1'b1;
        tick(1);
        ifb.start = 1'b0;
        check("s3_vec_e0", 32'(vec_b), 32'd0);
        tick(1);
        check("s3_vec_e1", 32'(vec_b), 32'd1);
        tick(14);                                  // after E15
        check("s3_done_e15", 32'(ifb.done), 32'd0);
        check("s3_busy_e15", 32'(ifb.busy), 32'd1);
        tick(1);                                   // after E16
        check("s3_done_e16", 32'(ifb.done), 32'd1);
        check("s3_errcnt",   32'(ifb.err_count), 32'd16);
        check("s3_first",    32'(ifb.first_err_vec), 32'd0);
        check("s3_errvld",   32'(ifb.err_valid), 32'd1);
        check("s3_pass",     32'(ifb.pass), 32'd0);
        check("s3_vec_end",  32'(vec_b), 32'd15);
        tick(1);

        // sweep 4: C, abort at vec_o=3 with one mismatch already seen
        ifc.tt_expected = 8'b1001_0111;
        ifc.start = 1'b1;
        tick(1);
        ifc.start = 1'b0;
        tick(9);                                   // after E9
        check("s4_vec_e9",   32'(vec_c), 32'd3);
        check("s4_errcnt_e9", 32'(ifc.err_count), 32'd1);
        ifc.abort = 1'b1;
        tick(1);                                   // after E10
        ifc.abort = 1'b0;
        check("s4_busy_ab",   32'(ifc.busy), 32'd0);
        check("s4_done_ab",   32'(ifc.done), 32'd0);
        check("s4_pass_ab",   32'(ifc.pass), 32'd0);
        check("s4_errcnt_ab", 32'(ifc.err_count), 32'd1);
        check("s4_errvld_ab", 32'(ifc.err_valid), 32'd1);
        check("s4_first_ab",  32'(ifc.first_err_vec), 32'd0);
`ifdef TT_SWEEP_OBSMAP_EN
        check("s4_obs_partial", 32'(ifc.obs_map), 32'h06);
`endif
        tick(1);
        check("s4_done_ab2", 32'(ifc.done), 32'd0);

        // sweep 5: C, start and abort together in IDLE -> start wins
        ifc.tt_expected = 8'b1001_0110;
        ifc.start = 1'b1;
        ifc.abort = 1'b1;
        tick(1);
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        check("s5_busy_e0",  32'(ifc.busy), 32'd1);
        check("s5_vec_e0",   32'(vec_c), 32'd0);
        check("s5_errcnt_clr", 32'(ifc.err_count), 32'd0);
        check("s5_errvld_clr", 32'(ifc.err_valid), 32'd0);
`ifdef TT_SWEEP_OBSMAP_EN
        check("s5_obs_clr", 32'(ifc.obs_map), 32'h00);
`endif
        tick(23);                                  // after E23
        check("s5_done_e23", 32'(ifc.done), 32'd0);
        tick(1);                                   // after E24
        check("s5_done_e24", 32'(ifc.done), 32'd1);
        check("s5_pass",     32'(ifc.pass), 32'd1);
        check("s5_errcnt",   32'(ifc.err_count), 32'd0);
`ifdef TT_SWEEP_OBSMAP_EN
        check("s5_obs_map", 32'(ifc.obs_map), 32'h96);
`endif
        tick(1);

        // sweep 6: A, async reset while vec_o=5
        ifa.tt_expected = 8'b0010_0011;
        ifa.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
        tick(10);                                  // after E10
        check("s6_vec_e10",  32'(vec_a), 32'd5);
        check("s6_errcnt_pre", 32'(ifa.err_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_vec",   32'(vec_a), 32'd0);
        check("s6_rst_busy",  32'(ifa.busy), 32'd0);
        check("s6_rst_done",  32'(ifa.done), 32'd0);
        check("s6_rst_errcnt", 32'(ifa.err_count), 32'd0);
        check("s6_rst_errvld", 32'(ifa.err_valid), 32'd0);
        check("s6_rst_first", 32'(ifa.first_err_vec), 32'd0);
        check("s6_rst_pass_b", 32'(ifb.err_count), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("s6_idle_after", 32'(ifa.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
